// File: rtl/exe_stage_unit.sv
// EXE stage: ALU, branch resolve and EX/MEM register. Single-cycle ops take 1 edge; MUL/DIVU/REMU take XLEN+2 edges under stall.
// `define EXE_MDU_EN builds the iterative multiply/divide unit; without it, cmds 9-11 complete in one cycle with result 0.
`timescale 1ns/1ps
module exe_stage_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [4:0]      dest_in,
  input  logic [XLEN-1:0] val1_in,
  input  logic [XLEN-1:0] val2_in,
  input  logic [XLEN-1:0] reg2_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [1:0]      br_type_in,
  input  logic [3:0]      exe_cmd_in,
  input  logic            mem_r_en_in,
  input  logic            mem_w_en_in,
  input  logic            wb_en_in,
  output logic            stall,
  output logic            br_taken,
  output logic [XLEN-1:0] br_addr,
  output logic            out_valid,
  output logic [4:0]      dest,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] st_data,
  output logic            mem_r_en,
  output logic            mem_w_en,
  output logic            wb_en
);

  logic [XLEN-1:0] w_alu;
  logic            w_br_cond;
  logic            w_idle;
  logic            w_is_mdu;

  logic            r_out_valid, r_mem_r_en, r_mem_w_en, r_wb_en;
  logic [4:0]      r_dest;
  logic [XLEN-1:0] r_alu_result, r_st_data;

  always_comb begin
    w_alu = '0;
    case (exe_cmd_in)
      4'd0:    w_alu = val1_in + val2_in;
      4'd1:    w_alu = val1_in - val2_in;
      4'd2:    w_alu = val1_in & val2_in;
      4'd3:    w_alu = val1_in | val2_in;
      4'd4:    w_alu = ~(val1_in | val2_in);
      4'd5:    w_alu = val1_in ^ val2_in;
      4'd6:    w_alu = val1_in << val2_in[4:0];
      4'd7:    w_alu = val1_in >> val2_in[4:0];
      4'd8:    w_alu = $unsigned($signed(val1_in) >>> val2_in[4:0]);
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    case (br_type_in)
      2'd1:    w_br_cond = (val1_in == reg2_in);
      2'd2:    w_br_cond = (val1_in != reg2_in);
      2'd3:    w_br_cond = 1'b1;
      default: w_br_cond = 1'b0;
    endcase
  end

  assign br_addr  = pc_in + (val2_in << 2);
  assign br_taken = ~rst & w_idle & in_valid & ~flush & w_br_cond;

`ifdef EXE_MDU_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t          r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]      r_op;
  // r_a: multiplier (shifts right) or dividend shifting into quotient; r_b: multiplicand or divisor
  logic [XLEN-1:0] r_a, r_b, r_acc, r_rem;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN-1:0] w_rem_sub, w_mdu_res;
  logic            w_ge, w_stall;
  logic [4:0]      r_c_dest;
  logic [XLEN-1:0] r_c_st;
  logic            r_c_mr, r_c_mw, r_c_wb;

  assign w_is_mdu  = (exe_cmd_in == 4'd9) | (exe_cmd_in == 4'd10) | (exe_cmd_in == 4'd11);
  assign w_idle    = (r_state == S_IDLE);
  assign w_rem_sh  = {r_rem, r_a[XLEN-1]};
  assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_b;
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_mdu_res = (r_op == 2'b01) ? r_acc : (r_op == 2'b10) ? r_a : r_rem;
  assign stall     = ~rst & w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: if (in_valid && !flush && w_is_mdu) begin
        w_next  = S_BUSY;
        w_stall = 1'b1;
      end
      S_BUSY: if (flush) begin
        w_next = S_IDLE;
      end else begin
        w_stall = 1'b1;
        if (r_cnt == CNT_W'(XLEN-1)) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0; r_op <= '0; r_a <= '0; r_b <= '0; r_acc <= '0; r_rem <= '0;
      r_c_dest <= '0; r_c_st <= '0; r_c_mr <= 1'b0; r_c_mw <= 1'b0; r_c_wb <= 1'b0;
    end else if (r_state == S_IDLE && w_next == S_BUSY) begin
      r_cnt <= '0; r_op <= exe_cmd_in[1:0]; r_a <= val1_in; r_b <= val2_in;
      r_acc <= '0; r_rem <= '0;
      r_c_dest <= dest_in; r_c_st <= reg2_in;
      r_c_mr <= mem_r_en_in; r_c_mw <= mem_w_en_in; r_c_wb <= wb_en_in;
    end else if (r_state == S_BUSY && !flush) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_op == 2'b01) begin
        if (r_a[0]) r_acc <= r_acc + r_b;
        r_a <= r_a >> 1;
        r_b <= r_b << 1;
      end else begin
        r_a   <= {r_a[XLEN-2:0], w_ge};
        r_rem <= w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
      end
    end
  end
`else
  assign w_is_mdu = 1'b0;
  assign w_idle   = 1'b1;
  assign stall    = 1'b0;
`endif

  // Bubble by default: valid/control drop, data fields keep their last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0; r_mem_r_en <= 1'b0; r_mem_w_en <= 1'b0; r_wb_en <= 1'b0;
      r_dest <= '0; r_alu_result <= '0; r_st_data <= '0;
    end else begin
      r_out_valid <= 1'b0; r_mem_r_en <= 1'b0; r_mem_w_en <= 1'b0; r_wb_en <= 1'b0;
      if (!flush) begin
`ifdef EXE_MDU_EN
        if (r_state == S_DONE) begin
          r_out_valid <= 1'b1; r_dest <= r_c_dest; r_alu_result <= w_mdu_res;
          r_st_data <= r_c_st; r_mem_r_en <= r_c_mr; r_mem_w_en <= r_c_mw; r_wb_en <= r_c_wb;
        end else
`endif
        if (w_idle && in_valid && !w_is_mdu) begin
          r_out_valid <= 1'b1; r_dest <= dest_in; r_alu_result <= w_alu;
          r_st_data <= reg2_in; r_mem_r_en <= mem_r_en_in; r_mem_w_en <= mem_w_en_in;
          r_wb_en <= wb_en_in;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign dest       = r_dest;
  assign alu_result = r_alu_result;
  assign st_data    = r_st_data;
  assign mem_r_en   = r_mem_r_en;
  assign mem_w_en   = r_mem_w_en;
  assign wb_en      = r_wb_en;

endmodule

// File: tb/tb_exe_stage_unit.sv
// Bench for exe_stage_unit: directed vectors, spec-level reference model, per-cycle compare on the falling edge.
`timescale 1ns/1ps
module tb_exe_stage_unit;
  localparam int XLEN = 32;
`ifdef EXE_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0;
  logic [4:0]  dest_in = '0;
  logic [31:0] val1_in = '0, val2_in = '0, reg2_in = '0, pc_in = '0;
  logic [1:0]  br_type_in = '0;
  logic [3:0]  exe_cmd_in = '0;
  logic        mem_r_en_in = 1'b0, mem_w_en_in = 1'b0, wb_en_in = 1'b0;
  logic        stall, br_taken, out_valid, mem_r_en, mem_w_en, wb_en;
  logic [31:0] br_addr, alu_result, st_data;
  logic [4:0]  dest;

  always #5 clk = ~clk;

  exe_stage_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .dest_in(dest_in),
    .val1_in(val1_in), .val2_in(val2_in), .reg2_in(reg2_in), .pc_in(pc_in),
    .br_type_in(br_type_in), .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .stall(stall), .br_taken(br_taken),
    .br_addr(br_addr), .out_valid(out_valid), .dest(dest), .alu_result(alu_result),
    .st_data(st_data), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mdu(input logic [3:0] c);
    return (c >= 4'd9) && (c <= 4'd11);
  endfunction

  // What alu_result must be for a command, straight from the arithmetic definition
  function automatic logic [31:0] f_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int unsigned sh;
    sh = b % 32;
    case (c)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ~(a | b);
      4'd5: r = a ^ b;
      4'd6: r = a << sh;
      4'd7: r = a >> sh;
      4'd8: r = (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd9: r = MDU_EN ? a * b : 32'h0;
      4'd10: r = !MDU_EN ? 32'h0 : (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd11: r = !MDU_EN ? 32'h0 : (b == 0) ? a : a % b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic bit f_branch(input logic [1:0] t, input logic [31:0] a, input logic [31:0] r2);
    return (t == 2'd1 && a == r2) || (t == 2'd2 && a != r2) || (t == 2'd3);
  endfunction

  // Model state: a pending long op counts down the edges left until its result appears
  logic        m_pend = 1'b0;
  int          m_left = 0;
  logic [31:0] m_res = '0, m_st = '0;
  logic [4:0]  m_dest = '0;
  logic        m_mr = 1'b0, m_mw = 1'b0, m_wb = 1'b0;
  logic        e_valid = 1'b0, e_mr = 1'b0, e_mw = 1'b0, e_wb = 1'b0;
  logic [4:0]  e_dest = '0;
  logic [31:0] e_alu = '0, e_st = '0;
  logic        exp_stall, exp_br;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 1'b0; m_left = 0;
      e_valid = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_wb = 1'b0;
      e_dest = '0; e_alu = '0; e_st = '0;
    end else begin
      e_valid = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_wb = 1'b0;
      if (flush) begin
        m_pend = 1'b0;
      end else if (m_pend) begin
        m_left--;
        if (m_left == 0) begin
          m_pend = 1'b0;
          e_valid = 1'b1; e_dest = m_dest; e_alu = m_res; e_st = m_st;
          e_mr = m_mr; e_mw = m_mw; e_wb = m_wb;
        end
      end else if (in_valid) begin
        if (MDU_EN && is_mdu(exe_cmd_in)) begin
          m_pend = 1'b1; m_left = XLEN + 1;
          m_res = f_result(exe_cmd_in, val1_in, val2_in);
          m_dest = dest_in; m_st = reg2_in;
          m_mr = mem_r_en_in; m_mw = mem_w_en_in; m_wb = wb_en_in;
        end else begin
          e_valid = 1'b1; e_dest = dest_in; e_st = reg2_in;
          e_alu = f_result(exe_cmd_in, val1_in, val2_in);
          e_mr = mem_r_en_in; e_mw = mem_w_en_in; e_wb = wb_en_in;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_stall = !rst && !flush &&
                (m_pend ? (m_left > 1) : (MDU_EN && in_valid && is_mdu(exe_cmd_in)));
    exp_br = !rst && !m_pend && in_valid && !flush && f_branch(br_type_in, val1_in, reg2_in);
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    chk("br_taken", {31'b0, br_taken}, {31'b0, exp_br});
    chk("br_addr", br_addr, pc_in + val2_in * 4);
    chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
    chk("dest", {27'b0, dest}, {27'b0, e_dest});
    chk("alu_result", alu_result, e_alu);
    chk("st_data", st_data, e_st);
    chk("ctrl", {29'b0, mem_r_en, mem_w_en, wb_en}, {29'b0, e_mr, e_mw, e_wb});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r2, input logic [4:0] d, input logic mw);
    in_valid = v; exe_cmd_in = cmd; val1_in = a; val2_in = b; reg2_in = r2; dest_in = d;
    mem_w_en_in = mw; mem_r_en_in = ~mw; wb_en_in = ~mw; br_type_in = 2'd0; pc_in = 32'h40;
  endtask

  task automatic alu_case(input string name, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    set_in(1'b1, cmd, a, b, a ^ b, cmd + 5'd1, cmd[0]);
    tick();
    chk(name, alu_result, exp);
  endtask

  task automatic run_long(input string name, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
    int n;
    n = 0;
    set_in(1'b1, cmd, a, b, 32'h1234_5678, 5'd9, 1'b0);
    #1;
    while (stall && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_stall_cycles"}, n, exp_stalls);
    tick();
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk(name, alu_result, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_alu", alu_result, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;

    set_in(1'b1, 4'd0, 32'd7, 32'hFFFF_FFFD, 32'h55, 5'd3, 1'b0);
    #1;
    chk("add_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("add_result", alu_result, 32'd4);
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_wb", {31'b0, wb_en}, 32'd1);
    chk("add_dest", {27'b0, dest}, 32'd3);

    set_in(1'b1, 4'd0, 32'd5, 32'd4, 32'd5, 5'd1, 1'b0);
    pc_in = 32'h100; br_type_in = 2'd1;
    #1;
    chk("beq_taken", {31'b0, br_taken}, 32'd1);
    chk("beq_addr", br_addr, 32'h110);
    br_type_in = 2'd2;
    #1;
    chk("bne_taken", {31'b0, br_taken}, 32'd0);
    tick();

    alu_case("sub", 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE);
    alu_case("and", 4'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
    alu_case("or", 4'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    alu_case("nor", 4'd4, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000);
    alu_case("xor", 4'd5, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    alu_case("sll", 4'd6, 32'd1, 32'h23, 32'd8);
    alu_case("srl", 4'd7, 32'h8000_0000, 32'd4, 32'h0800_0000);
    alu_case("sra", 4'd8, 32'h8000_0000, 32'h24, 32'hF800_0000);
    set_in(1'b0, 4'd0, 32'd1, 32'd1, 32'd0, 5'd2, 1'b0);
    tick();
    chk("bubble_valid", {31'b0, out_valid}, 32'd0);
    chk("bubble_hold", alu_result, 32'hF800_0000);
    alu_case("cmd13", 4'd13, 32'd5, 32'd6, 32'd0);
    alu_case("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);

    run_long("mul", 4'd9, 32'hFFFF_FFFF, 32'd3, MDU_EN ? 32'hFFFF_FFFD : 32'd0, MDU_EN ? 33 : 0);
    run_long("mul67", 4'd9, 32'd6, 32'd7, MDU_EN ? 32'd42 : 32'd0, MDU_EN ? 33 : 0);
    run_long("divu", 4'd10, 32'd100, 32'd7, MDU_EN ? 32'd14 : 32'd0, MDU_EN ? 33 : 0);
    run_long("remu", 4'd11, 32'd100, 32'd7, MDU_EN ? 32'd2 : 32'd0, MDU_EN ? 33 : 0);
    run_long("divu0", 4'd10, 32'd9, 32'd0, MDU_EN ? 32'hFFFF_FFFF : 32'd0, MDU_EN ? 33 : 0);
    run_long("remu0", 4'd11, 32'd9, 32'd0, MDU_EN ? 32'd9 : 32'd0, MDU_EN ? 33 : 0);

    set_in(1'b1, 4'd9, 32'd12, 32'd12, 32'd0, 5'd4, 1'b0);
    repeat (10) tick();
    flush = 1'b1;
    #1;
    chk("flush_stall", {31'b0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_bubble", {31'b0, out_valid}, 32'd0);
    set_in(1'b1, 4'd0, 32'd2, 32'd2, 32'd0, 5'd5, 1'b0);
    #1;
    chk("post_flush_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("post_flush_add", alu_result, 32'd4);
    chk("post_flush_valid", {31'b0, out_valid}, 32'd1);

    set_in(1'b1, 4'd10, 32'd50, 32'd5, 32'd0, 5'd6, 1'b0);
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_alu", alu_result, 32'd0);
    chk("rst_dest", {27'b0, dest}, 32'd0);
    tick();
    rst = 1'b0;
    set_in(1'b1, 4'd0, 32'd10, 32'd20, 32'd0, 5'd7, 1'b0);
    tick();
    chk("post_rst_add", alu_result, 32'd30);
    set_in(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
